l2_evict_ctrl: RTL and testbench

Allocation/eviction sequencer for one 8-way L2 set-associative array. Holds per-set valid, dirty and tree-PLRU state. On a miss-fill request it picks the lowest empty way, or else the PLRU victim, and runs a writeback handshake for dirty victims before granting the way. It sits between the L2 miss handler (allocation requester), the hit path (touch/invalidate) and the writeback buffer.

---
 rtl/l2_evict_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_l2_evict_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_evict_ctrl.sv
// Allocation/eviction sequencer for one 8-way L2 array: per-set valid/dirty/tree-PLRU,
// victim selection and writeback handshake. Optional counters under L2_EVICT_STATS_EN.
module l2_evict_ctrl #(
  parameter int INDEX_BITS = 4,
  parameter int WAYS       = 8,
  parameter int WAY_BITS   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_req,
  input  logic [INDEX_BITS-1:0] alloc_index,
  output logic                  alloc_ack,
  output logic [WAY_BITS-1:0]   alloc_way,
  input  logic                  touch_valid,
  input  logic [INDEX_BITS-1:0] touch_index,
  input  logic [WAY_BITS-1:0]   touch_way,
  input  logic                  touch_dirty,
  input  logic                  inv_valid,
  input  logic [INDEX_BITS-1:0] inv_index,
  input  logic [WAY_BITS-1:0]   inv_way,
  output logic                  upd_ready,
  output logic                  wb_req,
  output logic [INDEX_BITS-1:0] wb_index,
  output logic [WAY_BITS-1:0]   wb_way,
  input  logic                  wb_ack,
  output logic                  busy
`ifdef L2_EVICT_STATS_EN
  ,
  output logic [31:0]           evict_cnt,
  output logic [31:0]           wb_cnt
`endif
);

  localparam int SETS = 2 ** INDEX_BITS;

  typedef enum logic [1:0] {IDLE, LOOKUP, WB, GRANT} state_t;

  state_t                state, state_nxt;
  logic [WAYS-1:0]       valid_q [SETS];
  logic [WAYS-1:0]       dirty_q [SETS];
  logic [6:0]            plru_q  [SETS];
  logic [INDEX_BITS-1:0] idx_q;
  logic [WAY_BITS-1:0]   victim_q;
  logic [WAY_BITS-1:0]   victim_c;
  logic                  victim_valid_c;
  logic                  victim_dirty_c;

  // Point every tree node on the path of way w away from w.
  function automatic logic [6:0] plru_access(input logic [6:0] p, input logic [WAY_BITS-1:0] w);
    logic [6:0] r;
    r    = p;
    r[0] = ~w[2];
    if (!w[2]) begin
      r[1] = ~w[1];
      if (!w[1]) r[3] = ~w[0];
      else       r[4] = ~w[0];
    end else begin
      r[2] = ~w[1];
      if (!w[1]) r[5] = ~w[0];
      else       r[6] = ~w[0];
    end
    return r;
  endfunction

  function automatic logic [WAY_BITS-1:0] plru_victim(input logic [6:0] p);
    logic [WAY_BITS-1:0] w;
    w[2] = p[0];
    if (!p[0]) begin
      w[1] = p[1];
      w[0] = p[1] ? p[4] : p[3];
    end else begin
      w[1] = p[2];
      w[0] = p[2] ? p[6] : p[5];
    end
    return w;
  endfunction

  // Lowest empty way wins; a full set falls back to the PLRU choice.
  always_comb begin
    victim_valid_c = 1'b1;
    victim_c       = plru_victim(plru_q[idx_q]);
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_q[idx_q][i]) begin
        victim_valid_c = 1'b0;
        victim_c       = WAY_BITS'(i);
      end
    end
    victim_dirty_c = dirty_q[idx_q][victim_c];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    alloc_ack = 1'b0;
    alloc_way = '0;
    wb_req    = 1'b0;
    wb_index  = '0;
    wb_way    = '0;
    busy      = 1'b1;
    upd_ready = 1'b0;
    unique case (state)
      IDLE: begin
        busy      = 1'b0;
        upd_ready = 1'b1;
        if (alloc_req) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (victim_valid_c && victim_dirty_c) state_nxt = WB;
        else                                  state_nxt = GRANT;
      end
      WB: begin
        wb_req   = 1'b1;
        wb_index = idx_q;
        wb_way   = victim_q;
        if (wb_ack) state_nxt = GRANT;
      end
      GRANT: begin
        alloc_ack = 1'b1;
        alloc_way = victim_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request index and chosen victim; only read once the FSM has left IDLE.
  always_ff @(posedge clk) begin
    if (state == IDLE && alloc_req) idx_q <= alloc_index;
    if (state == LOOKUP)            victim_q <= victim_c;
  end

  // Inv is written after touch so it wins on a same-line collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else if (state == IDLE) begin
      if (touch_valid) begin
        plru_q[touch_index] <= plru_access(plru_q[touch_index], touch_way);
        if (touch_dirty) dirty_q[touch_index][touch_way] <= 1'b1;
      end
      if (inv_valid) begin
        valid_q[inv_index][inv_way] <= 1'b0;
        dirty_q[inv_index][inv_way] <= 1'b0;
      end
    end else if (state == GRANT) begin
      valid_q[idx_q][victim_q] <= 1'b1;
      dirty_q[idx_q][victim_q] <= 1'b0;
      plru_q[idx_q]            <= plru_access(plru_q[idx_q], victim_q);
    end
  end

`ifdef L2_EVICT_STATS_EN
  logic victim_was_valid_q;

  always_ff @(posedge clk) begin
    if (state == LOOKUP) victim_was_valid_q <= victim_valid_c;
  end

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evict_cnt <= '0;
      wb_cnt    <= '0;
    end else begin
      if (state == GRANT && victim_was_valid_q && evict_cnt != 32'hFFFF_FFFF)
        evict_cnt <= evict_cnt + 32'd1;
      if (state == WB && wb_ack && wb_cnt != 32'hFFFF_FFFF)
        wb_cnt <= wb_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l2_evict_ctrl.sv
// Directed table-driven bench for l2_evict_ctrl, plus a hand sequence for reset during WB.
module tb_l2_evict_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_req;
  logic [3:0] alloc_index;
  logic       alloc_ack;
  logic [2:0] alloc_way;
  logic       touch_valid;
  logic [3:0] touch_index;
  logic [2:0] touch_way;
  logic       touch_dirty;
  logic       inv_valid;
  logic [3:0] inv_index;
  logic [2:0] inv_way;
  logic       upd_ready;
  logic       wb_req;
  logic [3:0] wb_index;
  logic [2:0] wb_way;
  logic       wb_ack;
  logic       busy;
`ifdef L2_EVICT_STATS_EN
  logic [31:0] evict_cnt;
  logic [31:0] wb_cnt;
`endif

  l2_evict_ctrl #(.INDEX_BITS(4), .WAYS(8), .WAY_BITS(3)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_index(alloc_index), .alloc_ack(alloc_ack), .alloc_way(alloc_way),
    .touch_valid(touch_valid), .touch_index(touch_index), .touch_way(touch_way), .touch_dirty(touch_dirty),
    .inv_valid(inv_valid), .inv_index(inv_index), .inv_way(inv_way),
    .upd_ready(upd_ready),
    .wb_req(wb_req), .wb_index(wb_index), .wb_way(wb_way), .wb_ack(wb_ack),
    .busy(busy)
`ifdef L2_EVICT_STATS_EN
    , .evict_cnt(evict_cnt), .wb_cnt(wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  typedef enum {OP_ALLOC, OP_TOUCH, OP_INV, OP_TINV, OP_STATS} op_t;
  typedef struct {
    op_t op;
    int  idx;
    int  way;
    bit  dirty;
    int  exp_way;
    bit  exp_wb;
    int  wb_delay;
    int  exp_ev;
    int  exp_wbc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(op_t op, int idx, int way, bit d, int ew, bit ewb, int dl);
    vec_t v;
    v = '{op, idx, way, d, ew, ewb, dl, 0, 0};
    vecs.push_back(v);
  endfunction

  function automatic void add_stats(int ev, int wbc);
    vec_t v;
    v = '{OP_STATS, 0, 0, 1'b0, 0, 1'b0, 0, ev, wbc};
    vecs.push_back(v);
  endfunction

  task automatic do_update(input op_t op, input int idx, input int way, input bit d);
    @(negedge clk);
    check("upd_ready_idle", upd_ready, 1);
    touch_valid = (op == OP_TOUCH || op == OP_TINV);
    touch_index = 4'(idx);
    touch_way   = 3'(way);
    touch_dirty = d;
    inv_valid   = (op == OP_INV || op == OP_TINV);
    inv_index   = 4'(idx);
    inv_way     = 3'(way);
    @(negedge clk);
    touch_valid = 1'b0;
    inv_valid   = 1'b0;
    touch_dirty = 1'b0;
  endtask

  // Ack lands in the third cycle of a request (IDLE sample, LOOKUP, GRANT),
  // later by one cycle per WB cycle for a dirty victim.
  task automatic do_alloc(input int idx, input int exp_way, input bit exp_wb, input int dl);
    int n      = 0;
    int wbc    = 0;
    bit got    = 0;
    bit saw_wb = 0;
    @(negedge clk);
    alloc_req   = 1'b1;
    alloc_index = 4'(idx);
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      wb_ack = 1'b0;
      if (alloc_ack) begin
        got = 1;
      end else if (wb_req) begin
        if (!saw_wb) begin
          saw_wb = 1;
          check("wb_latency", n, 2);
          check("wb_index", wb_index, idx);
          check("wb_way", wb_way, exp_way);
        end
        if (wbc == dl) begin
          check("wb_hold_upd_ready", upd_ready, 0);
          check("wb_hold_busy", busy, 1);
          wb_ack = 1'b1;
        end
        wbc++;
      end else if (saw_wb) begin
        check("wb_req_held", 0, 1);
      end
    end
    alloc_req = 1'b0;
    wb_ack    = 1'b0;
    check("alloc_ack_seen", got, 1);
    check("alloc_way", alloc_way, exp_way);
    check("wb_req_seen", saw_wb, exp_wb);
    check("alloc_latency", n, exp_wb ? 3 + dl : 2);
    @(negedge clk);
    check("alloc_ack_pulse", alloc_ack, 0);
  endtask

  initial begin
    int n;
    bit saw;
    rst         = 1'b1;
    alloc_req   = 1'b0;
    alloc_index = '0;
    touch_valid = 1'b0;
    touch_index = '0;
    touch_way   = '0;
    touch_dirty = 1'b0;
    inv_valid   = 1'b0;
    inv_index   = '0;
    inv_way     = '0;
    wb_ack      = 1'b0;

    // Cold fills of set 0, then PLRU after touching 0..7 points at way 0.
    for (int w = 0; w < 8; w++) add(OP_ALLOC, 0, 0, 0, w, 0, 0);
    add_stats(0, 0);
    for (int w = 0; w < 8; w++) add(OP_TOUCH, 0, w, 0, 0, 0, 0);
    add(OP_ALLOC, 0, 0, 0, 0, 0, 0);
    // Set 3: dirty way 0 becomes the PLRU victim and needs a writeback.
    for (int w = 0; w < 8; w++) add(OP_ALLOC, 3, 0, 0, w, 0, 0);
    add(OP_TOUCH, 3, 0, 1, 0, 0, 0);
    for (int w = 1; w < 8; w++) add(OP_TOUCH, 3, w, 0, 0, 0, 0);
    add(OP_ALLOC, 3, 0, 0, 0, 1, 5);
    add_stats(2, 1);
    // Same victim again: it was cleaned by the grant, so no writeback.
    for (int w = 1; w < 8; w++) add(OP_TOUCH, 3, w, 0, 0, 0, 0);
    add(OP_ALLOC, 3, 0, 0, 0, 0, 0);
    // Set 5: an invalidated way beats the PLRU victim.
    for (int w = 0; w < 8; w++) add(OP_ALLOC, 5, 0, 0, w, 0, 0);
    add(OP_INV, 5, 6, 0, 0, 0, 0);
    add(OP_ALLOC, 5, 0, 0, 6, 0, 0);
    // Touch and inv on the same line: the line ends invalid and clean.
    add(OP_TINV, 5, 2, 1, 0, 0, 0);
    add(OP_ALLOC, 5, 0, 0, 2, 0, 0);
    add_stats(3, 1);
    // Set 7 prepared with a dirty PLRU victim for the reset-in-WB sequence.
    for (int w = 0; w < 8; w++) add(OP_ALLOC, 7, 0, 0, w, 0, 0);
    add(OP_TOUCH, 7, 0, 1, 0, 0, 0);
    for (int w = 1; w < 8; w++) add(OP_TOUCH, 7, w, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    check("rst_alloc_ack", alloc_ack, 0);
    check("rst_alloc_way", alloc_way, 0);
    check("rst_wb_req", wb_req, 0);
    check("rst_wb_index", wb_index, 0);
    check("rst_wb_way", wb_way, 0);
    check("rst_busy", busy, 0);
    check("rst_upd_ready", upd_ready, 1);
    rst = 1'b0;

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_ALLOC: do_alloc(vecs[i].idx, vecs[i].exp_way, vecs[i].exp_wb, vecs[i].wb_delay);
        OP_STATS: begin
`ifdef L2_EVICT_STATS_EN
          @(negedge clk);
          check("evict_cnt", evict_cnt, vecs[i].exp_ev);
          check("wb_cnt", wb_cnt, vecs[i].exp_wbc);
`endif
        end
        default:  do_update(vecs[i].op, vecs[i].idx, vecs[i].way, vecs[i].dirty);
      endcase
    end

    // Reset while waiting in WB drops wb_req at once and empties every set.
    @(negedge clk);
    alloc_req   = 1'b1;
    alloc_index = 4'd7;
    n   = 0;
    saw = 0;
    while (!saw && n < 10) begin
      @(negedge clk);
      n++;
      if (wb_req) saw = 1;
    end
    check("rst_wb_entered", saw, 1);
    check("rst_wb_way_before", wb_way, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_wb_req", wb_req, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_upd_ready", upd_ready, 1);
    check("rst_mid_alloc_ack", alloc_ack, 0);
    alloc_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
`ifdef L2_EVICT_STATS_EN
    check("rst_evict_cnt", evict_cnt, 0);
    check("rst_wb_cnt", wb_cnt, 0);
`endif
    do_alloc(7, 0, 0, 0);
    do_alloc(7, 1, 0, 0);
    do_alloc(0, 0, 0, 0);
`ifdef L2_EVICT_STATS_EN
    check("cold_evict_cnt", evict_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
